// File: rtl/chip8_sound_pkg.sv
// Shared types and constants for the CHIP-8 sound path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chip8_sound_pkg;

    // Beep sequencer states
    typedef enum logic [1:0] {
        IDLE,
        START_WAIT,
        PLAYING,
        DRAIN
    } sound_state_t;

    // Samples per sine period in the audio sample generator
    localparam int SINE_PERIOD = 100;

    // Width of one audio sample word
    localparam int SAMPLE_W = 16;

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
// Latency: first tick DIV-1 cycles after reset release, then every DIV cycles.
// Backpressure: none; the tick is a pulse and is never held off.
module tick_divider #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 60
) (
    input  logic main_clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    // Keep at least one counter bit so a degenerate divide-by-one still elaborates
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Count 0..DIV-1 and wrap on the tick cycle
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/sound_timer_ctrl.sv
// CHIP-8 sound timer: holds ST, decrements at TICK_HZ, gates the beep on whole sine periods.
// Latency: load -> timer_value +1 cycle, -> START_WAIT +2; sample_req in START_WAIT -> control +1.
// Backpressure: none; load and sample_req are single-cycle strobes always accepted.
module sound_timer_ctrl
    import chip8_sound_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 60,
    parameter int PERIOD  = SINE_PERIOD   // samples per sine period, 2..128
) (
    input  logic       main_clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       sample_req,
    output logic       control,
    output logic       phase_reset,
    output logic [7:0] timer_value,
    output logic       busy
);

    localparam logic [6:0] PH_LAST = 7'(PERIOD - 1);

    logic         tick;
    logic [7:0]   st;
    logic [6:0]   phase;
    sound_state_t state;
    sound_state_t state_nxt;
    logic         pr_nxt;
    logic         rearm;
    logic         sample_at_last;

    tick_divider #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_divider (
        .main_clk (main_clk),
        .reset    (reset),
        .tick     (tick)
    );

    assign timer_value    = st;
    assign rearm          = load && (load_value != 8'd0);
    assign sample_at_last = sample_req && (phase == PH_LAST);

    // Sound timer: a CPU write wins over a coincident tick; decrement saturates at 0
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            st <= 8'd0;
        end else if (load) begin
            st <= load_value;
        end else if (tick && (st != 8'd0)) begin
            st <= st - 8'd1;
        end
    end

    // Next-state decode; transitions look at the registered ST, so they trail it by one cycle
    always_comb begin
        state_nxt = state;
        pr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (st != 8'd0) begin
                    state_nxt = START_WAIT;
                end
            end
            START_WAIT: begin
                if (st == 8'd0) begin
                    state_nxt = IDLE;
                end else if (sample_req) begin
                    // Start exactly on a sample so the generator's index 0 lines up with the gate
                    state_nxt = PLAYING;
                    pr_nxt    = 1'b1;
                end
            end
            PLAYING: begin
                if (st == 8'd0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // A nonzero ST (fresh write, or one that landed as we entered DRAIN) keeps the tone going
                if (rearm || (st != 8'd0)) begin
                    state_nxt = PLAYING;
                end else if (sample_at_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered output decode
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            control     <= 1'b0;
            busy        <= 1'b0;
            phase_reset <= 1'b0;
        end else begin
            state       <= state_nxt;
            control     <= (state_nxt == PLAYING) || (state_nxt == DRAIN);
            busy        <= (state_nxt != IDLE);
            phase_reset <= pr_nxt;
        end
    end

    // Sine phase tracker: cleared on beep start, counts samples modulo PERIOD while sounding
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            phase <= 7'd0;
        end else if ((state == START_WAIT) && (state_nxt == PLAYING)) begin
            phase <= 7'd0;
        end else if (((state == PLAYING) || (state == DRAIN)) && sample_req) begin
            phase <= (phase == PH_LAST) ? 7'd0 : phase + 7'd1;
        end
    end

endmodule

// File: tb/tb_sound_timer_ctrl.sv
// Self-checking bench for sound_timer_ctrl with a small behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sound_timer_ctrl;

    localparam int CLK_HZ  = 600;
    localparam int TICK_HZ = 60;
    localparam int PER     = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic       main_clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_value;
    logic       sample_req;
    logic       control;
    logic       phase_reset;
    logic [7:0] timer_value;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: elapsed cycles, timer as integer, beep described by flags
    int m_cyc;
    int m_st;
    int m_phase;
    bit m_gate;     // tone audible
    bit m_wait;     // armed, waiting for a sample to align the start
    bit m_drain;    // timer expired, finishing the current period
    bit m_pr;

    int req_cnt   = 0;
    bit req_en    = 1'b1;
    bit req_rand  = 1'b0;
    int beep_reqs = 0;
    bit prev_ctrl = 1'b0;
    int pr_seen   = 0;
    int ctrl_seen = 0;

    always #5 main_clk = ~main_clk;

    sound_timer_ctrl #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .PERIOD  (PER)
    ) dut (
        .main_clk    (main_clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .sample_req  (sample_req),
        .control     (control),
        .phase_reset (phase_reset),
        .timer_value (timer_value),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc   = 0;
        m_st    = 0;
        m_phase = 0;
        m_gate  = 1'b0;
        m_wait  = 1'b0;
        m_drain = 1'b0;
        m_pr    = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs about to be sampled
    task automatic model_step();
        int st_old;
        int ph_old;
        bit tick_now;
        st_old   = m_st;
        ph_old   = m_phase;
        tick_now = ((m_cyc % DIV) == DIV - 1);
        m_cyc++;
        if (load) m_st = int'(load_value);
        else if (tick_now && m_st > 0) m_st = m_st - 1;
        m_pr = 1'b0;
        if (m_wait) begin
            if (st_old == 0) begin
                m_wait = 1'b0;
            end else if (sample_req) begin
                m_wait  = 1'b0;
                m_gate  = 1'b1;
                m_drain = 1'b0;
                m_phase = 0;
                m_pr    = 1'b1;
            end
        end else if (m_gate) begin
            if (sample_req) m_phase = (ph_old + 1) % PER;
            if (!m_drain) begin
                if (st_old == 0) m_drain = 1'b1;
            end else if ((load && load_value != 8'd0) || st_old != 0) begin
                m_drain = 1'b0;
            end else if (sample_req && ph_old == PER - 1) begin
                m_gate  = 1'b0;
                m_drain = 1'b0;
            end
        end else if (st_old != 0) begin
            m_wait = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("control", control, m_gate);
        chk("busy", busy, m_gate || m_wait);
        chk("timer_value", timer_value, m_st[7:0]);
        chk("phase_reset", phase_reset, m_pr);
        if (phase_reset) pr_seen++;
        if (control) ctrl_seen++;
        if (prev_ctrl && !control) begin
            chk("beep_whole_periods", beep_reqs % PER, 0);
            beep_reqs = 0;
        end
        prev_ctrl = control;
    endtask

    // Called just after a falling edge: drive inputs, step the model, compare at the next falling edge
    task automatic cyc(input logic ld, input logic [7:0] val);
        logic req;
        if (!req_en) req = 1'b0;
        else if (req_rand) req = ($urandom_range(0, 2) == 0);
        else req = ((req_cnt % 3) == 0);
        req_cnt++;
        load       = ld;
        load_value = val;
        sample_req = req;
        if (req && control) beep_reqs++;
        model_step();
        @(negedge main_clk);
        check_outputs();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((m_gate || m_wait || m_st != 0) && n < 400) begin
            cyc(1'b0, 8'd0);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        int n;
        int last_tv;
        int last_change;
        int ticks_seen;
        bit found;

        reset      = 1'b1;
        load       = 1'b0;
        load_value = 8'd0;
        sample_req = 1'b0;
        model_reset();
        @(negedge main_clk);
        chk("rst_control", control, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timer", timer_value, 0);
        chk("rst_phase_reset", phase_reset, 0);
        #2 reset = 1'b0;

        // Basic beep: load 3, watch the timer step down one per tick and the beep end on a period
        pr_seen = 0;
        ctrl_seen = 0;
        cyc(1'b1, 8'd3);
        chk("basic_load_tv", timer_value, 3);
        last_tv = 3;
        last_change = 0;
        ticks_seen = 0;
        n = 0;
        while ((busy || n < 5) && n < 300) begin
            cyc(1'b0, 8'd0);
            n++;
            if (int'(timer_value) != last_tv) begin
                chk("basic_tv_step", timer_value, 8'(last_tv - 1));
                if (ticks_seen > 0) chk("basic_tick_gap", 16'(n - last_change), DIV);
                ticks_seen++;
                last_tv = int'(timer_value);
                last_change = n;
            end
        end
        chk("basic_end_idle", busy, 0);
        chk("basic_tick_count", 16'(ticks_seen), 3);
        chk("basic_one_phase_reset", 16'(pr_seen), 1);
        chk("basic_control_seen", ctrl_seen != 0, 1);

        // Load/tick collision: load 5 in the very cycle a tick would take ST from 2 to 1
        cyc(1'b1, 8'd3);
        n = 0;
        while (!(((m_cyc % DIV) == DIV - 1) && m_st == 2) && n < 100) begin
            cyc(1'b0, 8'd0);
            n++;
        end
        cyc(1'b1, 8'd5);
        chk("collide_load_wins", timer_value, 5);
        for (int i = 1; i <= DIV; i++) begin
            cyc(1'b0, 8'd0);
            chk("collide_next_tick", timer_value, (i < DIV) ? 16'd5 : 16'd4);
        end
        wait_idle("collide_end_idle");

        // Re-arm while draining at phase 1: the gate must not blink and the phase must not restart
        found = 1'b0;
        for (int attempt = 0; attempt < 10 && !found; attempt++) begin
            wait_idle("rearm_pre_idle");
            for (int d = 0; d < int'($urandom_range(0, 5)); d++) cyc(1'b0, 8'd0);
            cyc(1'b1, 8'd1);
            n = 0;
            while (n < 80 && !found && (n < 3 || m_gate || m_wait)) begin
                if (m_gate && m_drain && m_phase == 1) found = 1'b1;
                else begin
                    cyc(1'b0, 8'd0);
                    n++;
                end
            end
        end
        chk("rearm_drain_phase1_reached", found, 1);
        if (found) begin
            pr_seen = 0;
            cyc(1'b1, 8'd2);
            for (int i = 0; i < 12; i++) begin
                chk("rearm_control_held", control, 1);
                cyc(1'b0, 8'd0);
            end
            chk("rearm_no_phase_reset", 16'(pr_seen), 0);
        end
        wait_idle("rearm_end_idle");

        // Cancel in START_WAIT before any sample arrives
        req_en = 1'b0;
        pr_seen = 0;
        ctrl_seen = 0;
        cyc(1'b1, 8'd4);
        chk("cancel_tv", timer_value, 4);
        cyc(1'b0, 8'd0);
        chk("cancel_armed_busy", busy, 1);
        cyc(1'b1, 8'd0);
        cyc(1'b0, 8'd0);
        chk("cancel_idle", busy, 0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'd0);
        chk("cancel_no_control", 16'(ctrl_seen), 0);
        chk("cancel_no_phase_reset", 16'(pr_seen), 0);
        req_en = 1'b1;

        // Saturation: 50 ticks in IDLE with ST already 0
        for (int i = 0; i < 50 * DIV; i++) begin
            cyc(1'b0, 8'd0);
            chk("sat_tv", timer_value, 0);
            chk("sat_busy", busy, 0);
        end

        // Asynchronous reset in the middle of a beep
        cyc(1'b1, 8'd3);
        n = 0;
        while (!control && n < 50) begin
            cyc(1'b0, 8'd0);
            n++;
        end
        cyc(1'b0, 8'd0);
        chk("arst_playing_before", control, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_control", control, 0);
        chk("arst_busy", busy, 0);
        chk("arst_timer", timer_value, 0);
        chk("arst_phase_reset", phase_reset, 0);
        model_reset();
        beep_reqs = 0;
        prev_ctrl = 1'b0;
        @(negedge main_clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'd0);
        chk("arst_idle_after", busy, 0);

        // Randomized traffic against the model
        req_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 29) == 0), 8'($urandom_range(0, 4)));
        end
        req_rand = 1'b0;
        wait_idle("random_end_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_timer_ctrl.md
# sound_timer_ctrl

- Sequencer for the CHIP-8 sound timer (ST) and the beep datapath.
- Holds the 8-bit ST written by the CPU (Fx18) and decrements it at 60 Hz.
- Drives the `control` gate of the sine-sample datapath, with every beep starting and ending on a sine-period boundary so there are no clicks.
- Sits between the CPU register-write path and the audio sample generator, in the main clock domain.

## Interface

Parameters:
- `CLK_HZ`, default 50_000_000: main clock frequency.
- `TICK_HZ`, default 60: timer decrement rate.
- `PERIOD`, default 100: samples per sine period. Must be 2..128.

Ports:
- `main_clk`  in  1: the only clock.
- `reset`  in  1: asynchronous, active-high.
- `load`  in  1: one-cycle ST write strobe.
- `load_value`  in  8: value written on `load`.
- `sample_req`  in  1: one-cycle pulse per audio sample, already synchronous to `main_clk`.
- `control`  out  1: beep gate to the sample generator.
- `phase_reset`  out  1: one-cycle pulse; the sample generator restarts its index at 0.
- `timer_value`  out  8: current ST.
- `busy`  out  1: high in any state other than IDLE.

## Operation

- **Prescaler**
  - DIV = CLK_HZ/TICK_HZ (integer division). Counter runs 0..DIV-1 and is free-running from reset.
  - `tick` is high for one cycle when the count equals DIV-1, then the count returns to 0.
- **Timer**
  - `load` writes `load_value`. `load` has priority over `tick` in the same cycle; that tick is lost.
  - On `tick` with ST≠0: ST−1. No wrap below 0.
- **Phase counter**
  - 7 bits. Counts `sample_req` modulo PERIOD in PLAYING and DRAIN.
  - Cleared to 0 on the START_WAIT→PLAYING transition.
- **FSM**
  - IDLE: `control`=0. Next-cycle ST≠0 (after load) → START_WAIT.
  - START_WAIT: `control`=0.
    - ST becomes 0 (load 0 or tick) → IDLE.
    - Otherwise on `sample_req` → PLAYING, with `phase_reset` pulsed in that same transition cycle.
  - PLAYING: `control`=1. ST reaches 0 → DRAIN.
  - DRAIN: `control`=1.
    - `load` with nonzero value → PLAYING; phase is not cleared.
    - Otherwise, `sample_req` while phase = PERIOD-1 → IDLE (phase wraps to 0).
- **Outputs and priorities**
  - `control` and `busy` are registered and decoded from the state.
  - Evaluation order within a cycle: reset, then ST update, then FSM transition using the updated ST.
- **Reset**
  - Async assert clears everything: state IDLE, ST=0, prescaler=0, phase=0, all outputs 0.
  - Reset mid-beep drops `control` immediately. The clean-stop guarantee does not apply.

## Timing

- `load` at cycle N → `timer_value` = new value at N+1, state START_WAIT at N+2.
- START_WAIT with `sample_req` at cycle N → `phase_reset`=1 during N+1, `control`=1 from N+1.
- `tick` at N with ST=1 → ST=0 at N+1, DRAIN at N+2.
- Beep length = ST×DIV cycles, then up to PERIOD samples of drain.
- Beep length is always a whole number of periods (±1 sample at start alignment).
- `sample_req` and `tick` in the same cycle are both honoured.
- `load` with value 0 during PLAYING → DRAIN at N+2.

## Structure

- Package `chip8_sound_pkg`:
  - `sound_state_t` enum {IDLE, START_WAIT, PLAYING, DRAIN}.
  - `SINE_PERIOD`=100 constant.
  - The shared sample-width constant (16).
- Sub-module `tick_divider` (params CLK_HZ, TICK_HZ; ports `main_clk`, `reset`, `tick`) for the prescaler, reused by the delay-timer block.
- Expected size: about 150–200 lines of RTL.

## Test plan

Bench parameters: CLK_HZ=600, TICK_HZ=60 (DIV=10), PERIOD=4. `sample_req` every 3 cycles.

- **Reset values:** assert `reset` asynchronously mid-PLAYING → `control`, `busy`, `timer_value`, `phase_reset` all 0 without waiting for a clock edge; IDLE after release.
- **Basic beep:** `load` 3 → `timer_value` 3, 2, 1, 0 at successive ticks (10 cycles apart).
  - `control` rises 1 cycle after the first `sample_req`, with a single `phase_reset` pulse.
  - `control` falls only after the `sample_req` where phase=3.
  - Total count of `sample_req` with `control`=1 is a multiple of 4.
- **Load/tick collision:** `load` 5 in the exact tick cycle with ST=2 → ST=5 next cycle; the next decrement comes 10 cycles later.
- **Re-arm in DRAIN:** ST hits 0, then `load` 2 while phase=1 → PLAYING, `control` stays continuously 1, no `phase_reset` pulse.
- **Cancel in START_WAIT:** `load` 4, then `load` 0 before any `sample_req` → IDLE, `control` never 1, `phase_reset` never pulsed.
- **Saturation:** IDLE with ST=0 across 50 ticks → `timer_value` stays 0 (no wrap to 255), `busy`=0.
